alt_vipvfr131_common_trigger_queue: RTL and testbench

ALT_VIPVFR131_COMMON_TRIGGER_QUEUE -- requirements
Module: alt_vipvfr131_common_trigger_queue

---
 rtl/alt_vipvfr131_common_pkg.sv | 19 +
 rtl/alt_vipvfr131_common_trigger_queue.sv | 100 ++++++++++
 tb/tb_alt_vipvfr131_common_trigger_queue.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alt_vipvfr131_common_pkg.sv
// Shared definitions for the alt_vipvfr131 common blocks.
// Holds the trigger-queue FSM state encoding.
package alt_vipvfr131_common_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } trig_state_e;

  function automatic logic stateIsReq(input trig_state_e s);
    return (s == ST_REQ);
  endfunction

  function automatic logic stateIsActive(input trig_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/alt_vipvfr131_common_trigger_queue.sv
// Counts synchronised trigger pulses and hands them one at a time to a
// downstream worker using a req/ack request and a done completion pulse.
module alt_vipvfr131_common_trigger_queue
  import alt_vipvfr131_common_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   trigger_in,
  input  logic                   clear_in,
  output logic                   req_out,
  input  logic                   ack_in,
  input  logic                   done_in,
  output logic                   busy_out,
  output logic [COUNT_WIDTH-1:0] pending_out,
  output logic                   overflow_out
);

  localparam logic [COUNT_WIDTH-1:0] PendMax  = '1;
  localparam logic [COUNT_WIDTH-1:0] PendZero = '0;
  localparam logic [COUNT_WIDTH-1:0] PendOne  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  trig_state_e            state_q, state_d;
  logic [COUNT_WIDTH-1:0] pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic                   req_q, busy_q;
  logic                   inc, transfer, hasWork;

  assign inc      = trigger_in & ~clear_in;
  assign transfer = stateIsReq(state_q) & ack_in;

  // Saturating counter: a trigger arriving at the ceiling is dropped and
  // flagged instead of wrapping; clear takes priority over everything.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (clear_in) begin
      pending_d  = PendZero;
      overflow_d = 1'b0;
    end else if (inc && !transfer) begin
      if (pending_q == PendMax) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PendOne;
      end
    end else if (!inc && transfer && (pending_q != PendZero)) begin
      pending_d = pending_q - PendOne;
    end
  end

  assign hasWork = (pending_d != PendZero);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hasWork) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // An accepted job always completes, even if clear arrives with the ack.
        if (transfer) begin
          state_d = ST_BUSY;
        end else if (clear_in) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_in) begin
          state_d = hasWork ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= PendZero;
      overflow_q <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      req_q      <= stateIsReq(state_d);
      busy_q     <= stateIsActive(state_d);
    end
  end

  assign req_out      = req_q;
  assign busy_out     = busy_q;
  assign pending_out  = pending_q;
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_alt_vipvfr131_common_trigger_queue.sv
// Directed self-checking bench for the trigger queue (default width and
// a narrow COUNT_WIDTH=2 instance for saturation).
module tb_alt_vipvfr131_common_trigger_queue;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0, clr = 1'b0, ack = 1'b0, done = 1'b0;
  logic       req, busy, ovf;
  logic [3:0] pend;
  logic       trig2 = 1'b0, clr2 = 1'b0, ack2 = 1'b0, done2 = 1'b0;
  logic       req2, busy2, ovf2;
  logic [1:0] pend2;
  int         checks = 0;
  int         failures = 0;

  always #5 clock = ~clock;

  alt_vipvfr131_common_trigger_queue #(.COUNT_WIDTH(4)) dut (
    .clock(clock), .rst_n(rst_n), .trigger_in(trig), .clear_in(clr),
    .req_out(req), .ack_in(ack), .done_in(done), .busy_out(busy),
    .pending_out(pend), .overflow_out(ovf)
  );

  alt_vipvfr131_common_trigger_queue #(.COUNT_WIDTH(2)) dut2 (
    .clock(clock), .rst_n(rst_n), .trigger_in(trig2), .clear_in(clr2),
    .req_out(req2), .ack_in(ack2), .done_in(done2), .busy_out(busy2),
    .pending_out(pend2), .overflow_out(ovf2)
  );

  // Advance one rising edge and settle just after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({req, busy, pend, ovf} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b exp=0000000", {req, busy, pend, ovf});
    end
    checks++;
    if ({req2, busy2, pend2, ovf2} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs2 got=%b exp=00000", {req2, busy2, pend2, ovf2});
    end
    @(negedge clock);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single;
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    checks++;
    if ({req, busy, pend} !== {1'b1, 1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL single_c1 req/busy/pend=%b/%b/%0d exp=1/1/1", req, busy, pend);
    end
    step(2);
    checks++;
    if ({req, pend} !== {1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL single_c3 req/pend=%b/%0d exp=1/1", req, pend);
    end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    checks++;
    if ({req, busy, pend} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("[TB] FAIL single_ack req/busy/pend=%b/%b/%0d exp=0/1/0", req, busy, pend);
    end
    step(4);
    checks++;
    if ({req, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL single_busy req/busy=%b/%b exp=0/1", req, busy);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++;
    if ({req, busy, pend, ovf} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL single_done got=%b exp=0000000", {req, busy, pend, ovf});
    end
  endtask

  task automatic test_back_to_back;
    ack = 1'b1;
    trig = 1'b1;
    step(1);
    checks++;
    if ({req, pend} !== {1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL b2b_e1 req/pend=%b/%0d exp=1/1", req, pend);
    end
    step(1);
    checks++;
    if ({req, busy, pend} !== {1'b0, 1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL b2b_e2 req/busy/pend=%b/%b/%0d exp=0/1/1", req, busy, pend);
    end
    step(1);
    trig = 1'b0;
    checks++;
    if (pend !== 4'd2) begin
      failures++;
      $display("[TB] FAIL b2b_e3 pend=%0d exp=2", pend);
    end
    step(2);
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++;
    if ({req, pend} !== {1'b1, 4'd2}) begin
      failures++;
      $display("[TB] FAIL b2b_job2req req/pend=%b/%0d exp=1/2", req, pend);
    end
    step(1);
    checks++;
    if ({req, busy, pend} !== {1'b0, 1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL b2b_job2acc req/busy/pend=%b/%b/%0d exp=0/1/1", req, busy, pend);
    end
    step(3);
    done = 1'b1;
    step(1);
    done = 1'b0;
    step(1);
    checks++;
    if ({req, busy, pend} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("[TB] FAIL b2b_job3acc req/busy/pend=%b/%b/%0d exp=0/1/0", req, busy, pend);
    end
    step(3);
    done = 1'b1;
    step(1);
    done = 1'b0;
    ack = 1'b0;
    checks++;
    if ({req, busy, pend, ovf} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL b2b_end got=%b exp=0000000", {req, busy, pend, ovf});
    end
  endtask

  task automatic test_saturation;
    trig2 = 1'b1;
    step(3);
    checks++;
    if ({pend2, ovf2, req2} !== {2'd3, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL sat_at_max pend/ovf/req=%0d/%b/%b exp=3/0/1", pend2, ovf2, req2);
    end
    step(2);
    trig2 = 1'b0;
    checks++;
    if ({pend2, ovf2, req2} !== {2'd3, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL sat_overflow pend/ovf/req=%0d/%b/%b exp=3/1/1", pend2, ovf2, req2);
    end
    clr2 = 1'b1;
    trig2 = 1'b1;
    step(1);
    trig2 = 1'b0;
    checks++;
    if ({pend2, ovf2, req2, busy2} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL sat_clear got=%b exp=00000", {pend2, ovf2, req2, busy2});
    end
    trig2 = 1'b1;
    step(1);
    trig2 = 1'b0;
    clr2 = 1'b0;
    checks++;
    if ({pend2, ovf2, req2} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL clear_beats_trigger got=%b exp=0000", {pend2, ovf2, req2});
    end
  endtask

  task automatic test_ignored_handshakes;
    ack = 1'b1;
    done = 1'b1;
    step(1);
    checks++;
    if ({req, busy, pend} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL idle_ignore got=%b exp=000000", {req, busy, pend});
    end
    ack = 1'b0;
    done = 1'b0;
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    done = 1'b1;
    step(2);
    done = 1'b0;
    checks++;
    if ({req, busy, pend} !== {1'b1, 1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL req_hold req/busy/pend=%b/%b/%0d exp=1/1/1", req, busy, pend);
    end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    done = 1'b1;
    step(1);
    done = 1'b0;
  endtask

  task automatic test_same_cycle;
    trig = 1'b1;
    step(1);
    ack = 1'b1;
    step(1);
    trig = 1'b0;
    ack = 1'b0;
    checks++;
    if ({req, busy, pend} !== {1'b0, 1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL same_cycle req/busy/pend=%b/%b/%0d exp=0/1/1", req, busy, pend);
    end
  endtask

  task automatic test_clear_busy;
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    checks++;
    if ({busy, pend} !== {1'b1, 4'd2}) begin
      failures++;
      $display("[TB] FAIL busy_queue busy/pend=%b/%0d exp=1/2", busy, pend);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);
    checks++;
    if ({req, busy, pend} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("[TB] FAIL clear_busy req/busy/pend=%b/%b/%0d exp=0/1/0", req, busy, pend);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++;
    if ({req, busy, pend} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL clear_busy_end got=%b exp=000000", {req, busy, pend});
    end
  endtask

  task automatic test_clear_transfer;
    trig = 1'b1;
    step(2);
    trig = 1'b0;
    ack = 1'b1;
    clr = 1'b1;
    step(1);
    ack = 1'b0;
    clr = 1'b0;
    checks++;
    if ({req, busy, pend} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("[TB] FAIL clear_xfer req/busy/pend=%b/%b/%0d exp=0/1/0", req, busy, pend);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
  endtask

  task automatic test_reset_midop;
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    trig = 1'b1;
    step(3);
    trig = 1'b0;
    checks++;
    if ({busy, pend} !== {1'b1, 4'd3}) begin
      failures++;
      $display("[TB] FAIL pre_reset busy/pend=%b/%0d exp=1/3", busy, pend);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req, busy, pend, ovf} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b exp=0000000", {req, busy, pend, ovf});
    end
    step(1);
    #2;
    rst_n = 1'b1;
    step(3);
    checks++;
    if ({req, busy, pend, ovf} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL post_release got=%b exp=0000000", {req, busy, pend, ovf});
    end
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    checks++;
    if ({req, busy, pend} !== {1'b1, 1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL first_after_reset req/busy/pend=%b/%b/%0d exp=1/1/1", req, busy, pend);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_ignored_handshakes();
    test_same_cycle();
    test_clear_busy();
    test_clear_transfer();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
